// File: rtl/prio_enc_hs.sv
// Active-low request encoder with a registered index and valid/ready handshake.
// Define RR_ARB_EN for round-robin arbitration; the default is fixed lowest-index priority.
module prio_enc_hs #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_n,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_multi,
  output logic             busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state;
  logic [N_REQ-1:0] req;
  logic             any_req;
  logic             multi;
  logic             capture;
  logic [IDX_W-1:0] win;

  assign req     = ~req_n;
  assign any_req = |req;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi   = |(req & (req - ONE));
  assign capture = any_req && ((state == IDLE) || out_ready);

`ifdef RR_ARB_EN
  logic [IDX_W-1:0] ptr;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (capture) ptr <= win + IDX_W'(1);
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win = IDX_W'(i);
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_idx   <= '0;
      out_multi <= 1'b0;
    end else begin
      if (capture) begin
        out_idx   <= win;
        out_multi <= multi;
      end
      case (state)
        IDLE:    if (any_req) state <= HOLD;
        HOLD:    if (out_ready && !any_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == HOLD);

endmodule
